// File: rtl/ecc11_point_index_sched_pkg.sv
// Shared constants, types and the GF(11) point table for the point-index scheduler.
package ecc11_pkg;
    localparam int PT_IDX_W = 4;
    localparam int NUM_PTS  = 16;
    localparam int P_MOD    = 11;

    typedef enum logic [1:0] {IDLE, CAPT, LOOK, OUT} state_t;

    typedef struct packed {
        logic                hit;
        logic [PT_IDX_W-1:0] idx;
    } pt_res_t;

    // Entry i holds the affine coordinates of point index i; index 0 is infinity.
    localparam int PT_X [NUM_PTS] = '{0, 5, 7, 10, 2, 1, 4, 6, 8, 9, 9, 8, 1, 4, 6, 2};
    localparam int PT_Y [NUM_PTS] = '{0, 0, 0, 0,  1, 2, 2, 2, 4, 5, 6, 7, 9, 9, 9, 10};
endpackage

// File: rtl/ecc11_point_index_sched_if.sv
// Requester/consumer bus of the point-index scheduler.
interface ecc11_point_index_sched_if #(
    parameter int NREQ = 2,
    parameter int CW   = 8
);
    import ecc11_pkg::*;
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*CW-1:0] req_x;
    logic [NREQ*CW-1:0] req_y;
    logic               out_valid;
    logic               out_ready;
    logic [PT_IDX_W-1:0] out_idx;
    logic               out_hit;
    logic [SRC_W-1:0]   out_src;

    modport slave (
        input  req_valid, req_x, req_y, out_ready,
        output req_ready, out_valid, out_idx, out_hit, out_src
    );

    modport master (
        output req_valid, req_x, req_y, out_ready,
        input  req_ready, out_valid, out_idx, out_hit, out_src
    );
endinterface

// File: rtl/ecc11_point_index_lut.sv
// Combinational (x,y) -> {hit, idx} match against the GF(11) point table.
module ecc11_point_index_lut
    import ecc11_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    output pt_res_t       res
);
    logic in_field;

    always_comb begin
        // Negative or >= p coordinates can never match, whatever their low bits say.
        in_field = !x[CW-1] && !y[CW-1] && (x < CW'(P_MOD)) && (y < CW'(P_MOD));
        res = '0;
        for (int i = 0; i < NUM_PTS; i++) begin
            if (in_field && (x == CW'(PT_X[i])) && (y == CW'(PT_Y[i]))) begin
                res.hit = 1'b1;
                res.idx = PT_IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/ecc11_point_index_sched.sv
// Round-robin shared point-to-index lookup: one request in flight, registered result
// with source id and a saturating off-curve counter.
module ecc11_point_index_sched
    import ecc11_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CW    = 8,
    parameter int ERR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ecc11_point_index_sched_if.slave   bus,
    output logic [ERR_W-1:0]           err_cnt,
    output logic                       busy
);
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t               state_q, state_d;
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        cap_x_q, cap_x_d;
    logic [CW-1:0]        cap_y_q, cap_y_d;
    logic [SRC_W-1:0]     cap_src_q, cap_src_d;
    logic                 out_valid_q, out_valid_d;
    logic [PT_IDX_W-1:0]  out_idx_q, out_idx_d;
    logic                 out_hit_q, out_hit_d;
    logic [SRC_W-1:0]     out_src_q, out_src_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 busy_q, busy_d;

    logic [NREQ-1:0]      grant;
    logic [SRC_W-1:0]     grant_idx;
    logic                 grant_any;
    int                   cand;
    pt_res_t              lut_res;

    ecc11_point_index_lut #(.CW(CW)) u_lut (
        .x   (cap_x_q),
        .y   (cap_y_q),
        .res (lut_res)
    );

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any       = 1'b1;
                grant_idx       = SRC_W'(cand);
                grant[cand]     = 1'b1;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cap_x_d     = cap_x_q;
        cap_y_d     = cap_y_q;
        cap_src_d   = cap_src_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_hit_d   = out_hit_q;
        out_src_d   = out_src_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    cap_x_d   = bus.req_x[int'(grant_idx)*CW +: CW];
                    cap_y_d   = bus.req_y[int'(grant_idx)*CW +: CW];
                    cap_src_d = grant_idx;
                    rr_ptr_d  = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
                    state_d   = CAPT;
                end
            end
            CAPT: state_d = LOOK;
            LOOK: begin
                out_idx_d   = lut_res.idx;
                out_hit_d   = lut_res.hit;
                out_src_d   = cap_src_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (!out_hit_q && (err_q != '1)) err_d = err_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cap_x_q     <= '0;
            cap_y_q     <= '0;
            cap_src_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_hit_q   <= 1'b0;
            out_src_q   <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cap_x_q     <= cap_x_d;
            cap_y_q     <= cap_y_d;
            cap_src_q   <= cap_src_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_hit_q   <= out_hit_d;
            out_src_q   <= out_src_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_src   = out_src_q;
    assign err_cnt       = err_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_ecc11_point_index_sched.sv
// Randomized + directed bench for ecc11_point_index_sched against a transaction-level model.
module tb_ecc11_point_index_sched;
    localparam int NREQ  = 2;
    localparam int CW    = 8;
    localparam int ERR_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ecc11_point_index_sched_if #(.NREQ(NREQ), .CW(CW)) bus();
    logic [ERR_W-1:0] err_cnt;
    logic             busy;

    ecc11_point_index_sched #(.NREQ(NREQ), .CW(CW), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Point list written straight from the index map.
    int tb_px [16] = '{0, 5, 7, 10, 2, 1, 4, 6, 8, 9, 9, 8, 1, 4, 6, 2};
    int tb_py [16] = '{0, 0, 0, 0,  1, 2, 2, 2, 4, 5, 6, 7, 9, 9, 9, 10};

    function automatic logic [4:0] ref_lookup(input logic [7:0] x, input logic [7:0] y);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        for (int i = 0; i < 16; i++)
            if (sx == tb_px[i] && sy == tb_py[i]) return {1'b1, 4'(i)};
        return 5'b0;
    endfunction

    function automatic logic [NREQ-1:0] ref_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (v[j]) return NREQ'(1) << j;
        end
        return '0;
    endfunction

    // Transaction model: at most one outstanding request, result due 3 cycles after accept.
    int              cyc = 0;
    logic            m_out = 1'b0;
    int              m_acc = 0;
    logic [4:0]      m_res = '0;
    int              m_src = 0;
    int              m_ptr = 0;
    int              m_err = 0;
    logic [NREQ-1:0] mon_rdy;
    logic            mon_vld;
    int              win;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_out = 1'b0;
            m_ptr = 0;
            m_err = 0;
        end else begin
            mon_rdy = m_out ? '0 : ref_grant(bus.req_valid, m_ptr);
            mon_vld = m_out && ((cyc - m_acc) >= 3);
            chk("req_ready", 32'(bus.req_ready), 32'(mon_rdy));
            chk("busy", 32'(busy), 32'(m_out));
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            chk("out_valid", 32'(bus.out_valid), 32'(mon_vld));
            if (mon_vld) begin
                chk("out_idx", 32'(bus.out_idx), 32'(m_res[3:0]));
                chk("out_hit", 32'(bus.out_hit), 32'(m_res[4]));
                chk("out_src", 32'(bus.out_src), 32'(m_src));
            end
            if (mon_vld && bus.out_ready) begin
                m_out = 1'b0;
                if (!m_res[4] && m_err < ERR_MAX) m_err++;
            end else if (!m_out && (mon_rdy != '0)) begin
                win = 0;
                for (int i = 0; i < NREQ; i++) if (mon_rdy[i]) win = i;
                m_out = 1'b1;
                m_acc = cyc;
                m_src = win;
                m_res = ref_lookup(bus.req_x[win*CW +: CW], bus.req_y[win*CW +: CW]);
                m_ptr = (win + 1) % NREQ;
            end
        end
    end

    task automatic wait_grant(input int i, output int n, output logic ok);
        ok = 1'b0;
        n  = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                ok = 1'b1;
                n  = k;
                break;
            end
        end
        if (!ok) fail_now("grant_wait");
        @(posedge clk); #1;
    endtask

    task automatic wait_out(output int lat, output logic ok);
        ok  = 1'b0;
        lat = 0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok  = 1'b1;
                lat = k;
                break;
            end
        end
        if (!ok) fail_now("out_valid_wait");
    endtask

    task automatic drain_out();
        logic ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.out_valid && bus.out_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("drain_wait");
        @(posedge clk); #1;
    endtask

    task automatic idle_wait();
        logic ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy && !bus.out_valid && bus.req_valid == '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("idle_wait");
        @(posedge clk); #1;
    endtask

    task automatic one_req(input int i, input logic [7:0] x, input logic [7:0] y,
                           input logic [4:0] exp, input string nm);
        int   n, lat;
        logic ok;
        bus.req_x[i*CW +: CW] = x;
        bus.req_y[i*CW +: CW] = y;
        bus.req_valid[i] = 1'b1;
        wait_grant(i, n, ok);
        bus.req_valid[i] = 1'b0;
        if (!ok) return;
        wait_out(lat, ok);
        if (!ok) begin
            @(posedge clk); #1;
            return;
        end
        chk({nm, "_lat"}, 32'(lat), 32'd3);
        chk({nm, "_idx"}, 32'(bus.out_idx), 32'(exp[3:0]));
        chk({nm, "_hit"}, 32'(bus.out_hit), 32'(exp[4]));
        chk({nm, "_src"}, 32'(bus.out_src), 32'(i));
        drain_out();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int              n, lat, g, c0, c1;
        logic            ok;
        logic [NREQ-1:0] gr;
        logic [7:0]      rx, ry;
        int              pk;

        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_out_src", 32'(bus.out_src), 32'd0);

        // Simultaneous pair from reset: req0 first, then req1.
        bus.req_x = {8'd8, 8'd5};
        bus.req_y = {8'd7, 8'd0};
        bus.req_valid = 2'b11;
        wait_grant(0, n, ok);
        chk("t2_first_grant_wait", 32'(n), 32'd0);
        bus.req_valid[0] = 1'b0;
        wait_out(lat, ok);
        chk("t2_r0_idx", 32'(bus.out_idx), 32'd1);
        chk("t2_r0_src", 32'(bus.out_src), 32'd0);
        drain_out();
        wait_grant(1, n, ok);
        chk("t2_second_grant_wait", 32'(n), 32'd0);
        bus.req_valid[1] = 1'b0;
        wait_out(lat, ok);
        chk("t2_r1_idx", 32'(bus.out_idx), 32'd11);
        chk("t2_r1_src", 32'(bus.out_src), 32'd1);
        drain_out();

        // Both held valid: grants must alternate starting with req0.
        bus.req_valid = 2'b11;
        g = 0; c0 = 0; c1 = 0;
        for (int k = 0; k < 200 && g < 20; k++) begin
            @(negedge clk);
            gr = bus.req_valid & bus.req_ready;
            if (gr != '0) begin
                chk("t2_rr_seq", 32'(gr), (g % 2 == 0) ? 32'd1 : 32'd2);
                if (gr[0]) c0++;
                if (gr[1]) c1++;
                g++;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("t2_rr_cnt0", 32'(c0), 32'd10);
        chk("t2_rr_cnt1", 32'(c1), 32'd10);
        idle_wait();

        one_req(0, 8'd2, 8'd10, {1'b1, 4'd15}, "t1");

        one_req(0, 8'd3, 8'd3, {1'b0, 4'd0}, "t3_off");
        chk("t3_err_after_off", 32'(err_cnt), 32'd1);
        one_req(0, 8'd0, 8'd0, {1'b1, 4'd0}, "t3_inf");
        chk("t3_err_after_inf", 32'(err_cnt), 32'd1);

        // Consumer stalls 5 cycles with another request pending.
        bus.out_ready = 1'b0;
        bus.req_x[0 +: CW] = 8'd4;
        bus.req_y[0 +: CW] = 8'd9;
        bus.req_valid[0] = 1'b1;
        wait_grant(0, n, ok);
        bus.req_valid[0] = 1'b0;
        bus.req_x[CW +: CW] = 8'd2;
        bus.req_y[CW +: CW] = 8'd1;
        bus.req_valid[1] = 1'b1;
        wait_out(lat, ok);
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_hold_idx", 32'(bus.out_idx), 32'd13);
            chk("t4_hold_src", 32'(bus.out_src), 32'd0);
            chk("t4_hold_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_grant(1, n, ok);
        bus.req_valid[1] = 1'b0;
        idle_wait();

        one_req(0, 8'hFF, 8'd0, {1'b0, 4'd0}, "t5_neg");
        for (int k = 0; k < 300; k++) begin
            rx = 8'(11 + $urandom_range(0, 100));
            one_req(k % 2, rx, 8'($urandom), {1'b0, 4'd0}, "t5_sat");
        end
        chk("t5_err_sat", 32'(err_cnt), 32'(ERR_MAX));

        // Reset during LOOK drops the in-flight request.
        bus.req_x[0 +: CW] = 8'd1;
        bus.req_y[0 +: CW] = 8'd9;
        bus.req_valid[0] = 1'b1;
        wait_grant(0, n, ok);
        bus.req_valid[0] = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_idx", 32'(bus.out_idx), 32'd0);
        chk("t6_rst_hit", 32'(bus.out_hit), 32'd0);
        chk("t6_rst_src", 32'(bus.out_src), 32'd0);
        chk("t6_rst_err", 32'(err_cnt), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        one_req(0, 8'd1, 8'd9, {1'b1, 4'd12}, "t6_again");

        // Random traffic with random consumer back-pressure.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            gr = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (gr[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        if ($urandom_range(0, 1) == 1) begin
                            pk = $urandom_range(0, 15);
                            rx = 8'(tb_px[pk]);
                            ry = 8'(tb_py[pk]);
                        end else begin
                            rx = 8'($urandom);
                            ry = 8'($urandom_range(0, 12));
                        end
                        bus.req_x[i*CW +: CW] = rx;
                        bus.req_y[i*CW +: CW] = ry;
                        bus.req_valid[i] = 1'b1;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        idle_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
